// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_DROP = 3'd4
  } fetch_state_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Combinational next-PC logic: redirect detection, aligned target, sequential pc + 4.
module pc_next
  import fetch_pkg::*;
(
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic [31:0] pc,
  output logic        redirect,
  output logic [31:0] target,
  output logic [31:0] pc_seq
);

  // Jump has priority when both redirect sources fire together.
  always_comb begin
    redirect = branch | jump;
    target   = 32'h0000_0000;
    if (jump) begin
      target = word_align(jump_target);
    end else begin
      target = word_align(branch_target);
    end
    pc_seq = pc + PC_STEP;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding imem requests and
// hands fetched instructions to decode, squashing wrong-path fetches on redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready
);

  fetch_state_t state_r;
  logic [31:0]  pc_r;
  logic         req_r;
  logic         valid_r;
  logic [31:0]  instr_r;
  logic [31:0]  if_pc_r;
  logic         redirect_s;
  logic [31:0]  target_s;
  logic [31:0]  pc_seq_s;

  pc_next u_pc_next (
    .branch        (branch),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .pc            (pc_r),
    .redirect      (redirect_s),
    .target        (target_s),
    .pc_seq        (pc_seq_s)
  );

  // Fetch FSM; imem_req is registered alongside every transition into or out of REQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      pc_r    <= word_align(RESET_PC);
      req_r   <= 1'b0;
      valid_r <= 1'b0;
      instr_r <= INSTR_NOP;
      if_pc_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        S_IDLE: begin
          state_r <= S_REQ;
          req_r   <= 1'b1;
        end
        S_REQ: begin
          if (redirect_s) begin
            pc_r <= target_s;
            if (imem_gnt) begin
              state_r <= S_DROP;
              req_r   <= 1'b0;
            end
          end else if (imem_gnt) begin
            state_r <= S_WAIT;
            req_r   <= 1'b0;
          end
        end
        S_WAIT: begin
          if (redirect_s) begin
            pc_r <= target_s;
            if (imem_rvalid) begin
              state_r <= S_REQ;
              req_r   <= 1'b1;
            end else begin
              state_r <= S_DROP;
            end
          end else if (imem_rvalid) begin
            instr_r <= imem_rdata;
            if_pc_r <= pc_r;
            valid_r <= 1'b1;
            pc_r    <= pc_seq_s;
            state_r <= S_HOLD;
          end
        end
        S_HOLD: begin
          // A squashed instruction is dropped without a decode handshake.
          if (redirect_s) begin
            pc_r    <= target_s;
            valid_r <= 1'b0;
            state_r <= S_REQ;
            req_r   <= 1'b1;
          end else if (id_ready) begin
            valid_r <= 1'b0;
            state_r <= S_REQ;
            req_r   <= 1'b1;
          end
        end
        S_DROP: begin
          if (redirect_s) begin
            pc_r <= target_s;
          end
          if (imem_rvalid) begin
            state_r <= S_REQ;
            req_r   <= 1'b1;
          end
        end
        default: begin
          state_r <= S_IDLE;
          req_r   <= 1'b0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = req_r;
  assign imem_addr = pc_r;
  assign if_valid  = valid_r;
  assign if_instr  = instr_r;
  assign if_pc     = if_pc_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with hand-computed expected values.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        branch;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;

  int vectors;
  int miscompares;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .branch        (branch),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .id_ready      (id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From REQ at address a: grant, 1-cycle response with data d, end in HOLD.
  task automatic fetch_one(input logic [31:0] a, input logic [31:0] d);
    check("req_high", {31'd0, imem_req}, 32'd1);
    check("req_addr", imem_addr, a);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    check("wait_req_low", {31'd0, imem_req}, 32'd0);
    check("wait_valid_low", {31'd0, if_valid}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = d;
    tick();
    imem_rvalid = 1'b0;
    check("hold_valid", {31'd0, if_valid}, 32'd1);
    check("hold_pc", if_pc, a);
    check("hold_instr", if_instr, d);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    branch        = 1'b0;
    branch_target = 32'h0000_0000;
    jump          = 1'b0;
    jump_target   = 32'h0000_0000;
    imem_gnt      = 1'b0;
    imem_rvalid   = 1'b0;
    imem_rdata    = 32'h0000_0000;
    id_ready      = 1'b0;
    #1;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0000_0000);
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_instr", if_instr, 32'h0000_0013);
    check("rst_if_pc", if_pc, 32'h0000_0000);

    // Reset release; IDLE for one cycle, then REQ.
    tick();
    rst = 1'b0;
    check("idle_req", {31'd0, imem_req}, 32'd0);
    tick();

    // Sequential fetch 0, 4, 8 with id_ready high.
    fetch_one(32'h0000_0000, 32'h0000_0000);
    id_ready = 1'b1;
    tick();
    check("seq_valid_drop0", {31'd0, if_valid}, 32'd0);
    fetch_one(32'h0000_0004, 32'h0000_0004);
    tick();
    check("seq_valid_drop1", {31'd0, if_valid}, 32'd0);
    id_ready = 1'b0;
    fetch_one(32'h0000_0008, 32'h0000_0008);

    // Decode stalls for 5 cycles in HOLD.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", {31'd0, if_valid}, 32'd1);
      check("stall_pc", if_pc, 32'h0000_0008);
      check("stall_instr", if_instr, 32'h0000_0008);
      check("stall_req", {31'd0, imem_req}, 32'd0);
    end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    check("stall_release_valid", {31'd0, if_valid}, 32'd0);

    // Branch in WAIT before the response: orphaned response dropped.
    check("br_req_addr", imem_addr, 32'h0000_000C);
    imem_gnt = 1'b1;
    tick();
    imem_gnt      = 1'b0;
    branch        = 1'b1;
    branch_target = 32'h0000_0103;
    tick();
    branch = 1'b0;
    check("drop_req", {31'd0, imem_req}, 32'd0);
    check("drop_addr", imem_addr, 32'h0000_0100);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    check("drop_discard_valid", {31'd0, if_valid}, 32'd0);
    fetch_one(32'h0000_0100, 32'h0000_0100);

    // Branch and jump together in HOLD: jump wins, held instruction squashed.
    branch        = 1'b1;
    branch_target = 32'h0000_0200;
    jump          = 1'b1;
    jump_target   = 32'h0000_0300;
    tick();
    branch = 1'b0;
    jump   = 1'b0;
    check("squash_valid", {31'd0, if_valid}, 32'd0);
    check("squash_req", {31'd0, imem_req}, 32'd1);
    check("squash_addr", imem_addr, 32'h0000_0300);

    // Jump in REQ without grant, then PC wrap at the top of memory.
    jump        = 1'b1;
    jump_target = 32'hFFFF_FFFE;
    tick();
    jump = 1'b0;
    fetch_one(32'hFFFF_FFFC, 32'h1234_5678);
    id_ready = 1'b1;
    tick();
    check("wrap_addr", imem_addr, 32'h0000_0000);
    id_ready = 1'b0;
    fetch_one(32'h0000_0000, 32'h0000_00AA);
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    check("pre_rst_addr", imem_addr, 32'h0000_0004);

    // Asynchronous reset in WAIT, then a stray response after release.
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_req", {31'd0, imem_req}, 32'd0);
    check("async_rst_valid", {31'd0, if_valid}, 32'd0);
    check("async_rst_addr", imem_addr, 32'h0000_0000);
    tick();
    rst         = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0BAD;
    tick();
    check("stray_valid", {31'd0, if_valid}, 32'd0);
    tick();
    imem_rvalid = 1'b0;
    check("stray_valid2", {31'd0, if_valid}, 32'd0);
    check("stray_instr", if_instr, 32'h0000_0013);
    fetch_one(32'h0000_0000, 32'h0000_0055);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
